iob_ram_sp_ctrl: RTL and testbench
==================================

# iob_ram_sp_ctrl

Request controller placed directly upstream of the single-port synchronous RAM (en/we/addr/din/dout, 1-cycle registered read, dout held on writes). It accepts IOb-native valid/ready requests with per-byte write strobes, performs read-modify-write for partial writes because the RAM has no byte enables, and returns read data with an rvalid pulse. An optional post-reset sweep clears the whole RAM to zero before the first request is accepted.

## Interface
- DATA_W, 32: data width; multiple of 8.
- ADDR_W, 14: word address width; RAM depth 2**ADDR_W.
- CLEAR, 0: 1 = zero-fill the RAM after every reset before accepting requests.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid  in  1  request present.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes; all zero = read.
- ready  out  1  request accepted this cycle when valid&ready.
- rdata  out  DATA_W  read data, valid while rvalid.
- rvalid  out  1  one-cycle read response pulse.
- init_done  out  1  clear sweep finished (constant 1 after reset if CLEAR=0).
- ram_en, ram_we  out  1  RAM enable / write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM registered read data.

## Operation
- States: CLR (zero sweep), IDLE, RMW.
- Reset (rst_n=0 at edge): state = CLR if CLEAR=1 else IDLE; clear counter=0; rvalid=0; init_done=CLEAR?0:1; latched addr/wdata/wstrb=0. While rst_n=0: ready=0, ram_en=0, ram_we=0.
- CLR: ram_en=ram_we=1, ram_addr=counter, ram_din=0, ready=0; counter increments each cycle; at counter=2**ADDR_W-1 write it, go IDLE, init_done=1 next cycle. Counter never wraps past the last address.
- IDLE: ready=1. RAM ports driven combinationally from the request when valid:
  - Read (wstrb=0): ram_en=1, ram_we=0, ram_addr=addr; stay IDLE; rvalid=1 next cycle, rdata=ram_dout.
  - Full write (wstrb all ones): ram_en=ram_we=1, ram_din=wdata; stay IDLE; no rvalid.
  - Partial write (other wstrb): ram_en=1, ram_we=0 (read old word); latch addr/wdata/wstrb; go RMW; no rvalid.
- RMW: ready=0; ram_en=ram_we=1, ram_addr=latched addr; ram_din byte i = latched wstrb[i] ? latched wdata byte i : ram_dout byte i; go IDLE.
- valid=0 in IDLE: ram_en=0.
- rdata is ram_dout passed through; meaningful only while rvalid=1.

## Timing
- Read: accept cycle N, rvalid=1 in N+1 only; back-to-back reads sustain one per cycle.
- Full write: 1 cycle, RAM written at end of accept cycle.
- Partial write: 2 cycles, ready=0 in N+1, RAM written at end of N+1; next request accepted N+2.
- Read accepted immediately after any write to the same address returns the new data.
- rvalid never asserted for writes, RMW reads or CLR.
- Reset asserted during RMW: write abandoned, no RAM write in the reset cycle; reset during CLR restarts sweep at address 0.
- CLEAR=1: first request accepted 2**ADDR_W cycles after rst_n deasserts; init_done rises the cycle after the last clear write.
- Requests with valid=1 while ready=0 are ignored and must be held by the master.

## Test plan
- DATA_W=32, ADDR_W=4, CLEAR=1: release reset -> ram_we=1 for exactly 16 cycles at addresses 0..15 with din=0, ready=0 throughout, init_done=1 after; read addr 7 -> rdata=0x00000000.
- Full write addr 3 = 0xDEADBEEF, then read addr 3 next cycle -> rvalid one cycle later with rdata=0xDEADBEEF; ready stays 1.
- Partial write addr 3 wstrb=4'b0101 wdata=0x11223344 -> ready=0 one cycle; read -> 0xDE22BE44.
- Back-to-back reads addr 0,1,2 with prior contents 0xA0,0xA1,0xA2 -> rvalid high three consecutive cycles, data in order.
- rst_n low during RMW cycle of partial write to addr 5 (old 0x55555555) -> ram_we=0 that cycle; after reset (CLEAR=0) addr 5 reads 0x55555555.
- valid held high through RMW with a read of addr 9 -> read accepted only when ready=1, single rvalid returned.

Source files
------------

// File: rtl/iob_ram_sp_ctrl.sv
// Request controller in front of a single-port synchronous RAM: IOb valid/ready
// requests, read-modify-write for partial strobes, optional post-reset zero sweep.
module iob_ram_sp_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int CLEAR  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                init_done,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLR,
    ST_IDLE,
    ST_RMW
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic                init_done_q, init_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   merged;

  // Old word arrives on ram_dout during the RMW cycle; overlay the latched bytes.
  always_comb begin
    merged = ram_dout;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (wstrb_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rvalid_d    = 1'b0;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ready       = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr;
    ram_din     = wdata;

    unique case (state_q)
      ST_CLR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          ram_en = 1'b1;
          if (wstrb == '0) begin
            rvalid_d = 1'b1;
          end else if (wstrb == '1) begin
            ram_we = 1'b1;
          end else begin
            addr_d  = addr;
            wdata_d = wdata;
            wstrb_d = wstrb;
            state_d = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = addr_q;
        ram_din  = merged;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset cycle must not touch the RAM, even mid-RMW.
    if (!rst_n) begin
      ready  = 1'b0;
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR != 0) ? ST_CLR : ST_IDLE;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      init_done_q <= (CLEAR == 0);
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = ram_dout;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_iob_ram_sp_ctrl.sv
// Bench for iob_ram_sp_ctrl: instance 0 with CLEAR=1, instance 1 with CLEAR=0,
// each backed by a behavioural RAM; read responses checked by a scoreboard.
module tb_iob_ram_sp_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        valid     [2];
  logic [3:0]  addr      [2];
  logic [31:0] wdata     [2];
  logic [3:0]  wstrb     [2];
  logic        ready     [2];
  logic [31:0] rdata     [2];
  logic        rvalid    [2];
  logic        init_done [2];
  logic        ram_en    [2];
  logic        ram_we    [2];
  logic [3:0]  ram_addr  [2];
  logic [31:0] ram_din   [2];
  logic [31:0] ram_dout  [2];

  iob_ram_sp_ctrl #(.DATA_W(32), .ADDR_W(4), .CLEAR(1)) dut_clr (
    .clk(clk), .rst_n(rst_n[0]), .valid(valid[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .ready(ready[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .init_done(init_done[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
    .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0])
  );

  iob_ram_sp_ctrl #(.DATA_W(32), .ADDR_W(4), .CLEAR(0)) dut_noclr (
    .clk(clk), .rst_n(rst_n[1]), .valid(valid[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .ready(ready[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .init_done(init_done[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
    .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Power-up RAM contents, known to both the RAM and the reference model.
  function automatic logic [31:0] init_word(input int k, input int i);
    if (k == 1 && i == 5) return 32'h5555_5555;
    return 32'hC0DE_0000 + 32'h0101_0101 * (i + 1) + 32'h0010_0000 * k;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM: 1-cycle registered read, dout held on writes.
  logic [31:0] mem [2][16];
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) mem[k][i] = init_word(k, i);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ram_en[k]) begin
          if (ram_we[k]) mem[k][ram_addr[k]] <= ram_din[k];
          else           ram_dout[k]         <= mem[k][ram_addr[k]];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model + scoreboard: acceptance is observed at the negedge before
  // the accepting edge; a read must return its word exactly one cycle later.
  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] model [2][16];
  logic        pend  [2];
  logic [3:0]  paddr [2];
  logic [31:0] pdata [2];
  logic [3:0]  pstrb [2];

  initial begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0;
      for (int i = 0; i < 16; i++) model[k][i] = init_word(k, i);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rvalid[k] === 1'b1) begin
          n_tests++;
          if (sbq.size() == 0 || sbq[0].k != k) begin
            n_fail++;
            $display("FAIL rvalid_unexpected[%0d]: got rvalid=1 rdata=%h expected no response", k, rdata[k]);
          end else begin
            e = sbq.pop_front();
            if (e.due != cyc || rdata[k] !== e.data) begin
              n_fail++;
              $display("FAIL read_data[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                       k, rdata[k], cyc, e.data, e.due);
            end
          end
        end else if (sbq.size() > 0 && sbq[0].k == k && sbq[0].due <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL rvalid_missing[%0d]: got rvalid=0 expected response %h", k, sbq[0].data);
          void'(sbq.pop_front());
        end

        if (rst_n[k] !== 1'b1) begin
          sbq.delete();
          pend[k] = 1'b0;
          if (k == 0) for (int i = 0; i < 16; i++) model[0][i] = '0;
        end else begin
          if (pend[k]) begin
            model[k][paddr[k]] = merge(model[k][paddr[k]], pdata[k], pstrb[k]);
            pend[k] = 1'b0;
          end
          if (valid[k] && ready[k] === 1'b1) begin
            if (wstrb[k] == 4'h0) begin
              e.k = k; e.due = cyc + 1; e.data = model[k][addr[k]];
              sbq.push_back(e);
            end else if (wstrb[k] == 4'hF) begin
              model[k][addr[k]] = wdata[k];
            end else begin
              pend[k]  = 1'b1;
              paddr[k] = addr[k];
              pdata[k] = wdata[k];
              pstrb[k] = wstrb[k];
            end
          end
        end
      end
    end
  end

  // Present a request and hold it until accepted; returns cycles spent waiting.
  task automatic req(input int k, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int waited);
    valid[k] = 1'b1; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (ready[k] === 1'b1) break;
      waited++;
      if (waited > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL req_timeout[%0d]: got ready=0 for %0d cycles expected acceptance", k, waited);
        break;
      end
    end
    @(posedge clk); #1;
    valid[k] = 1'b0;
    wstrb[k] = 4'h0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [3:0] a, s;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; valid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end
    valid[0] = 1'b1;  // must be ignored while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", ready[0], 0);
    chk("rst_ram_en0", ram_en[0], 0);
    chk("rst_ram_we0", ram_we[0], 0);
    chk("rst_init_done0", init_done[0], 0);
    chk("rst_rvalid0", rvalid[0], 0);
    chk("rst_init_done1", init_done[1], 1);
    chk("rst_ready1", ready[1], 0);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr_we", ram_we[0], 1);
      chk("clr_addr", ram_addr[0], i);
      chk("clr_din", ram_din[0], 0);
      chk("clr_ready", ready[0], 0);
      chk("clr_init_done", init_done[0], 0);
    end
    @(negedge clk);
    chk("clr_done_init", init_done[0], 1);
    chk("clr_done_ready", ready[0], 1);
    chk("clr_done_we", ram_we[0], 0);
    chk("noclr_ready", ready[1], 1);
    @(posedge clk); #1;

    req(0, 4'd7, 32'h0, 4'h0, w);
    req(0, 4'd3, 32'hDEAD_BEEF, 4'hF, w);
    req(0, 4'd3, 32'h0, 4'h0, w);
    chk("full_wr_ready_stays", w, 0);
    req(0, 4'd3, 32'h1122_3344, 4'b0101, w);
    req(0, 4'd3, 32'h0, 4'h0, w);
    chk("partial_wr_stall", w, 1);

    req(0, 4'd0, 32'hA0, 4'hF, w);
    req(0, 4'd1, 32'hA1, 4'hF, w);
    req(0, 4'd2, 32'hA2, 4'hF, w);
    for (int i = 0; i < 3; i++) begin
      req(0, 4'(i), 32'h0, 4'h0, w);
      chk("b2b_read_nostall", w, 0);
    end

    req(0, 4'd9, 32'hCAFE_F00D, 4'b0110, w);
    req(0, 4'd9, 32'h0, 4'h0, w);
    chk("held_read_wait", w, 1);

    for (int n = 0; n < 200; n++) begin
      a = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 3: s = 4'h0;
        1:    s = 4'hF;
        default: s = 4'($urandom_range(1, 14));
      endcase
      req(0, a, $urandom, s, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(negedge clk);
    chk("sb_drained0", sbq.size(), 0);
    @(posedge clk); #1;

    req(1, 4'd5, 32'hFFFF_FFFF, 4'b0011, w);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("rst_in_rmw_we", ram_we[1], 0);
    chk("rst_in_rmw_en", ram_en[1], 0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    req(1, 4'd5, 32'h0, 4'h0, w);
    chk("after_rst_no_wait", w, 0);
    req(1, 4'd5, 32'h0000_AB00, 4'b0010, w);
    req(1, 4'd5, 32'h0, 4'h0, w);
    req(1, 4'd6, 32'h0, 4'h0, w);

    repeat (3) @(negedge clk);
    chk("sb_drained1", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
